seg7_reader: RTL and testbench
==============================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical synchronized samples required before a digit is accepted (legal range 2..255).
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 seg  input  7  7-segment bus, active-low, bit0=a .. bit6=g; asynchronous to clk.
REQ-005 an  input  4  digit-select bus, active-low, an[i]=0 selects digit i; asynchronous to clk.
REQ-006 value  output  16  last complete frame; value[4i+3:4i] = hex digit i.
REQ-007 valid  output  1  one-cycle pulse, value updated this cycle.
REQ-008 err  output  1  one-cycle pulse, an undecodable non-blank pattern was accepted.

Function
REQ-009 seg and an SHALL each pass through a 2-flop synchronizer; all further logic uses the second-stage outputs (sseg, san).
REQ-010 The stability counter SHALL increment, saturating at STABLE_CYCLES, while {san,sseg} equals its value on the previous cycle, and SHALL reload to 1 on any change.
REQ-011 An accept event SHALL occur on exactly the cycle the counter first reaches STABLE_CYCLES; no further accepts until {san,sseg} changes and is stable again.
REQ-012 An accept SHALL be ignored (no capture, no err) unless san has exactly one bit low; multiple-low and all-high san are ignored.
REQ-013 Decode table (sseg -> nibble): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->b, 1000110->C, 0100001->d, 0000110->E, 0001110->F.
REQ-014 Accept with sseg=1111111 (blank) SHALL be ignored with no capture and no err.
REQ-015 Accept with any other pattern not in REQ-013 SHALL pulse err for one cycle, the cycle after the accept, and SHALL clear captured-mask bit i of the selected digit.
REQ-016 A valid accept SHALL write the nibble into shadow register slot i and set captured-mask bit i; a repeat capture of digit i before frame completion overwrites slot i.
REQ-017 When the mask becomes 4'b1111, the block SHALL on the next cycle copy shadow to value, pulse valid for one cycle, and clear the mask.
REQ-018 Latency: pin change to accept is 2 synchronizer cycles + STABLE_CYCLES cycles; accept to valid/err is 1 cycle.
REQ-019 A capture landing on the same cycle as the mask clear of REQ-017 SHALL be preserved as mask bit set for the next frame.
REQ-020 value SHALL hold between valid pulses; valid and err SHALL never be high together for the same accept.

Reset
REQ-021 On rst_n low, asynchronously: synchronizer stages to all ones, counter=0, shadow=0, mask=0, value=16'h0000, valid=0, err=0.
REQ-022 Deassertion of rst_n mid-frame SHALL discard any partial frame; first valid requires four fresh captures.

Verification
REQ-023 Drive digits 0..3 with patterns 3,A,0,F, each held 10 cycles, STABLE_CYCLES=4 -> single valid pulse, value=16'hF0A3, err never high.
REQ-024 Hold an=1110 and seg=0100100 for 3 cycles then change to 0000000 -> no accept of "2"; "8" accepted after 6 cycles of stability.
REQ-025 Present an=1101 with seg=1111111, then seg=1010101 -> blank ignored silently; err pulse exactly once for 1010101, mask bit1 clear.
REQ-026 an=1100 with a valid pattern held 20 cycles -> no capture, no err, no valid.
REQ-027 Capture digits 0,1,2, capture digit 1 again with new value 7, then digit 3 -> valid with value[7:4]=4'h7.
REQ-028 Assert rst_n low after three captures, release, capture one digit -> no valid; value=16'h0000 until four new captures.

Source files
------------

// File: rtl/seg7_reader_if.sv
// Bundles the multiplexed 7-segment display pins and the decoded frame outputs.
interface seg7_reader_if;
  logic [6:0]  seg;    // active-low segments, bit0 = a .. bit6 = g
  logic [3:0]  an;     // active-low digit selects
  logic [15:0] value;  // last complete frame, nibble i = digit i
  logic        valid;  // one-cycle pulse when value updates
  logic        err;    // one-cycle pulse on an undecodable accepted pattern

  modport master (output seg, an, input value, valid, err);
  modport slave  (input seg, an, output value, valid, err);
endinterface

// File: rtl/seg7_reader.sv
// Reads a multiplexed, active-low 7-segment display and reassembles the four hex digits
// into a 16-bit frame once every digit has been seen stable and decodable.
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic          clk,
  input logic          rst_n,
  seg7_reader_if.slave bus_io
);

  localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

  logic [6:0]  seg_s1_q, sseg_q;
  logic [3:0]  an_s1_q, san_q;
  logic [10:0] prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        accept;
  logic [3:0]  nibble;
  logic        digit_ok, blank;
  logic [1:0]  sel_idx;
  logic        sel_ok;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  // Two-flop synchronizers for the asynchronous display pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      sseg_q   <= '1;
      an_s1_q  <= '1;
      san_q    <= '1;
    end else begin
      seg_s1_q <= bus_io.seg;
      sseg_q   <= seg_s1_q;
      an_s1_q  <= bus_io.an;
      san_q    <= an_s1_q;
    end
  end

  // Stability counter: saturating count of identical consecutive samples.
  always_comb begin
    cnt_d = 8'd1;
    if ({san_q, sseg_q} == prev_q) begin
      cnt_d = (cnt_q < StableMax) ? cnt_q + 8'd1 : cnt_q;
    end
    // Accept only on the cycle the count first reaches the threshold.
    accept = (cnt_d == StableMax) && (cnt_q != StableMax);
  end

  // Segment pattern to hex nibble.
  always_comb begin
    nibble   = 4'h0;
    digit_ok = 1'b1;
    blank    = 1'b0;
    case (sseg_q)
      7'b1000000: nibble = 4'h0;
      7'b1111001: nibble = 4'h1;
      7'b0100100: nibble = 4'h2;
      7'b0110000: nibble = 4'h3;
      7'b0011001: nibble = 4'h4;
      7'b0010010: nibble = 4'h5;
      7'b0000010: nibble = 4'h6;
      7'b1111000: nibble = 4'h7;
      7'b0000000: nibble = 4'h8;
      7'b0010000: nibble = 4'h9;
      7'b0001000: nibble = 4'hA;
      7'b0000011: nibble = 4'hB;
      7'b1000110: nibble = 4'hC;
      7'b0100001: nibble = 4'hD;
      7'b0000110: nibble = 4'hE;
      7'b0001110: nibble = 4'hF;
      7'b1111111: begin
        digit_ok = 1'b0;
        blank    = 1'b1;
      end
      default:    digit_ok = 1'b0;
    endcase
  end

  // Digit select must have exactly one low bit to be meaningful.
  always_comb begin
    sel_idx = 2'd0;
    sel_ok  = 1'b1;
    case (san_q)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase
  end

  // Capture into the shadow frame and publish it when all four digits are present.
  always_comb begin
    shadow_d = shadow_q;
    // A full mask lives for one cycle; a capture in that cycle starts the next frame.
    mask_d   = (mask_q == 4'hF) ? 4'h0 : mask_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (accept && sel_ok && !blank) begin
      if (digit_ok) begin
        shadow_d[{sel_idx, 2'b00} +: 4] = nibble;
        mask_d[sel_idx]                 = 1'b1;
      end else begin
        err_d           = 1'b1;
        mask_d[sel_idx] = 1'b0;
      end
    end
    if (mask_d == 4'hF) begin
      value_d = shadow_d;
      valid_d = 1'b1;
    end
  end

  // Counter, frame and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '1;
      cnt_q    <= '0;
      shadow_q <= '0;
      mask_q   <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= {san_q, sseg_q};
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign bus_io.value = value_q;
  assign bus_io.valid = valid_q;
  assign bus_io.err   = err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with STABLE_CYCLES = 4.
module tb_seg7_reader;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;
  int   valid_cyc = -1;
  int   err_cyc = -1;
  int   drive_cyc;
  int   v0, e0;

  seg7_reader_if bus ();

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
    end
    if (bus.err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (bus.valid && bus.err) both_cnt <= both_cnt + 1;
  end

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: enc = 7'b1000000;   1: enc = 7'b1111001;   2: enc = 7'b0100100;
      3: enc = 7'b0110000;   4: enc = 7'b0011001;   5: enc = 7'b0010010;
      6: enc = 7'b0000010;   7: enc = 7'b1111000;   8: enc = 7'b0000000;
      9: enc = 7'b0010000;  10: enc = 7'b0001000;  11: enc = 7'b0000011;
      12: enc = 7'b1000110; 13: enc = 7'b0100001;  14: enc = 7'b0000110;
      default: enc = 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive pins now (just after a rising edge) and hold for n cycles.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    bus.an  = a;
    bus.seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic digit(input int idx, input int d);
    logic [3:0] a;
    a = 4'hF;
    a[idx] = 1'b0;
    hold(a, enc(d), 10);
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_value", 32'(bus.value), 32'h0);
    chk("reset_valid", 32'(bus.valid), 32'h0);
    chk("reset_err", 32'(bus.err), 32'h0);
    rst_n = 1'b1;
    hold(4'hF, 7'h7F, 5);

    // Basic frame 3,A,0,F.
    digit(0, 3);
    digit(1, 10);
    digit(2, 0);
    drive_cyc = cyc;
    digit(3, 15);
    hold(4'hF, 7'h7F, 5);
    chk("frame1_valid_count", 32'(valid_cnt), 32'd1);
    chk("frame1_err_count", 32'(err_cnt), 32'd0);
    chk("frame1_value", 32'(bus.value), 32'hF0A3);
    chk("frame1_latency", 32'(valid_cyc), 32'(drive_cyc + 6));

    // Short-lived "2" must not be accepted; the following "8" must.
    hold(4'b1110, enc(2), 3);
    hold(4'b1110, enc(8), 10);
    digit(1, 1);
    digit(2, 2);
    digit(3, 5);
    hold(4'hF, 7'h7F, 5);
    chk("glitch_value", 32'(bus.value), 32'h5218);
    chk("glitch_valid_count", 32'(valid_cnt), 32'd2);
    chk("glitch_err_count", 32'(err_cnt), 32'd0);

    // Blank ignored, undecodable pattern flags err and drops the digit.
    digit(1, 9);
    chk("mask_after_capture", 32'(dut.mask_q), 32'h2);
    hold(4'b1101, 7'h7F, 10);
    chk("blank_err_count", 32'(err_cnt), 32'd0);
    chk("blank_mask", 32'(dut.mask_q), 32'h2);
    drive_cyc = cyc;
    hold(4'b1101, 7'b1010101, 10);
    chk("bad_err_count", 32'(err_cnt), 32'd1);
    chk("bad_err_latency", 32'(err_cyc), 32'(drive_cyc + 6));
    chk("bad_mask", 32'(dut.mask_q), 32'h0);
    chk("bad_no_valid", 32'(valid_cnt), 32'd2);

    // Two digit selects low at once: nothing happens.
    hold(4'b1100, enc(4), 20);
    chk("multisel_mask", 32'(dut.mask_q), 32'h0);
    chk("multisel_err", 32'(err_cnt), 32'd1);
    chk("multisel_valid", 32'(valid_cnt), 32'd2);

    // Repeat capture of digit 1 overwrites its slot.
    digit(0, 1);
    digit(1, 2);
    digit(2, 3);
    digit(1, 7);
    chk("overwrite_no_early_valid", 32'(valid_cnt), 32'd2);
    digit(3, 4);
    chk("overwrite_valid_count", 32'(valid_cnt), 32'd3);
    chk("overwrite_value", 32'(bus.value), 32'h4371);
    chk("overwrite_nibble1", 32'(bus.value[7:4]), 32'h7);

    // Reset mid-frame discards the partial frame.
    digit(0, 5);
    digit(1, 6);
    digit(2, 8);
    hold(4'hF, 7'h7F, 2);
    rst_n = 1'b0;
    #1;
    chk("midreset_value", 32'(bus.value), 32'h0);
    hold(4'hF, 7'h7F, 3);
    rst_n = 1'b1;
    hold(4'hF, 7'h7F, 3);
    v0 = valid_cnt;
    e0 = err_cnt;
    digit(3, 9);
    hold(4'hF, 7'h7F, 5);
    chk("postreset_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("postreset_value_held", 32'(bus.value), 32'h0);
    digit(0, 10);
    digit(1, 11);
    chk("postreset_still_no_valid", 32'(valid_cnt - v0), 32'd0);
    digit(2, 12);
    hold(4'hF, 7'h7F, 5);
    chk("postreset_valid", 32'(valid_cnt - v0), 32'd1);
    chk("postreset_value", 32'(bus.value), 32'h9CBA);
    chk("postreset_err", 32'(err_cnt - e0), 32'd0);
    chk("never_valid_and_err", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
